// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver:
// hex segment table (active-low form), blank pattern, select-width and polarity helpers.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Segment patterns {a,b,c,d,e,f,g}, active-low, indexed by hex value
    localparam logic [6:0] HEX_SEG_LOW [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Digit-select width; a single-digit display still gets a 1-bit select
    function automatic int unsigned sel_w(input int unsigned num_digits);
        return (num_digits <= 1) ? 32'd1 : 32'($clog2(num_digits));
    endfunction

    // Hex nibble to active-low segment pattern
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG_LOW[nib];
    endfunction

    // Active-low segment pattern to board polarity
    function automatic logic [6:0] seg_polarity(input logic [6:0] seg_low, input logic active_low);
        return active_low ? seg_low : ~seg_low;
    endfunction

    // Logical "on" to board polarity for a single pin
    function automatic logic bit_polarity(input logic on, input logic active_low);
        return active_low ? ~on : on;
    endfunction

endpackage

// File: rtl/seven_seg_tick_gen.sv
// Free-running modulo-DIV counter; tick_c is high during the terminal-count cycle.
module seven_seg_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_c
);

    localparam int unsigned CNT_W = (DIV <= 1) ? 1 : $clog2(DIV);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick_c = (count == TERM);

    // Count 0..DIV-1 and wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick_c) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed multi-digit seven-segment driver with per-digit dp,
// digit/dp blink and frame-synchronous display updates.
// Optional: SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never blanked).
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            en,
    input  logic                            update,
    input  logic [4*NUM_DIGITS-1:0]         digits,
    input  logic [NUM_DIGITS-1:0]           dp_in,
    input  logic [NUM_DIGITS-1:0]           blink_mask,
    input  logic [NUM_DIGITS-1:0]           dp_blink_mask,
    output logic [6:0]                      segments,
    output logic                            dec_point,
    output logic [NUM_DIGITS-1:0]           anode,
    output logic [sel_w(NUM_DIGITS)-1:0]    digit_sel,
    output logic                            frame_done
);

    localparam int unsigned SEL_W = sel_w(NUM_DIGITS);
    localparam logic AL = (ACTIVE_LOW != 0);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_OFF = seg_polarity(SEG_BLANK, AL);
    localparam logic DP_OFF = bit_polarity(1'b0, AL);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{AL}};

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blink;
        logic [NUM_DIGITS-1:0]   dp_blink;
    } frame_t;

    frame_t                  in_frame;
    frame_t                  staging;
    frame_t                  shadow;
    logic                    pending;
    logic                    refresh_tick_c;
    logic                    blink_tick_c;
    logic                    wrap_c;
    logic                    blink_phase;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;
    logic [NUM_DIGITS-1:0]   anode_nxt;

    assign in_frame = '{digits: digits, dp: dp_in, blink: blink_mask, dp_blink: dp_blink_mask};

    seven_seg_tick_gen #(.DIV(REFRESH_DIV)) u_refresh_tick (
        .clk    (clk),
        .rst_n  (reset),
        .tick_c (refresh_tick_c)
    );

    seven_seg_tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
        .clk    (clk),
        .rst_n  (reset),
        .tick_c (blink_tick_c)
    );

    // Last digit's terminal-count cycle: the frame boundary
    assign wrap_c = refresh_tick_c && (digit_sel == LAST_SEL);

    // Scan position and frame-wrap pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_sel  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap_c;
            if (wrap_c) begin
                digit_sel <= '0;
            end else if (refresh_tick_c) begin
                digit_sel <= digit_sel + SEL_W'(1);
            end
        end
    end

    // Blink phase: 0 = visible, 1 = blanked half-period
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_phase <= 1'b0;
        end else if (blink_tick_c) begin
            blink_phase <= ~blink_phase;
        end
    end

    // Stage updates and commit them to the shadow copy only at a frame boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            staging <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else if (wrap_c) begin
            if (update) begin
                shadow <= in_frame;
            end else if (pending) begin
                shadow <= staging;
            end
            pending <= 1'b0;
        end else if (update) begin
            staging <= in_frame;
            pending <= 1'b1;
        end
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // A digit is blanked when it and every more-significant digit are zero
    always_comb begin
        logic zero_above;
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            zero_above = zero_above && (shadow.digits[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
            if ((NUM_DIGITS - 1 - j) != 0) begin
                lz_blank[NUM_DIGITS-1-j] = zero_above;
            end
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Select the scanned digit and build next pin values
    always_comb begin
        logic [3:0]            cur_nib;
        logic                  cur_dp;
        logic                  cur_blink;
        logic                  cur_dp_blink;
        logic                  cur_lz;
        logic [NUM_DIGITS-1:0] anode_on;
        logic [6:0]            seg_low;
        logic                  dp_on;

        cur_nib      = 4'h0;
        cur_dp       = 1'b0;
        cur_blink    = 1'b0;
        cur_dp_blink = 1'b0;
        cur_lz       = 1'b0;
        anode_on     = '0;
        seg_low      = SEG_BLANK;
        dp_on        = 1'b0;

        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (digit_sel == SEL_W'(i)) begin
                cur_nib      = shadow.digits[4*i +: 4];
                cur_dp       = shadow.dp[i];
                cur_blink    = shadow.blink[i];
                cur_dp_blink = shadow.dp_blink[i];
                cur_lz       = lz_blank[i];
                anode_on[i]  = 1'b1;
            end
        end

        if (en) begin
            seg_low = cur_lz ? SEG_BLANK : hex_to_seg(cur_nib);
            dp_on   = cur_dp;
            if (blink_phase && cur_blink) begin
                seg_low = SEG_BLANK;
                dp_on   = 1'b0;
            end
            if (blink_phase && cur_dp_blink) begin
                dp_on = 1'b0;
            end
        end

        seg_nxt   = seg_polarity(seg_low, AL);
        dp_nxt    = bit_polarity(dp_on, AL);
        anode_nxt = en ? (AL ? ~anode_on : anode_on) : ANODE_OFF;
    end

    // Registered pin drivers; reset forces everything inactive immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anode     <= ANODE_OFF;
            segments  <= SEG_OFF;
            dec_point <= DP_OFF;
        end else begin
            anode     <= anode_nxt;
            segments  <= seg_nxt;
            dec_point <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed self-checking bench for seven_seg_scan_driver
// (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=32, ACTIVE_LOW=1).
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        update;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_blink_mask;
    logic [6:0]  segments;
    logic        dec_point;
    logic [3:0]  anode;
    logic [1:0]  digit_sel;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    seven_seg_scan_driver #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .BLINK_DIV   (32),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .update        (update),
        .digits        (digits),
        .dp_in         (dp_in),
        .blink_mask    (blink_mask),
        .dp_blink_mask (dp_blink_mask),
        .segments      (segments),
        .dec_point     (dec_point),
        .anode         (anode),
        .digit_sel     (digit_sel),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    // Clock edges since the last reset release
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    function automatic logic [6:0] exp_digit_seg(input logic [15:0] v, input int d);
        logic [3:0] nib;
        nib = v[4*d +: 4];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if (d != 0 && (v >> (4*d)) == 16'h0) return 7'b1111111;
`endif
        return hex_seg(nib);
    endfunction

    function automatic logic [3:0] exp_anode(input int d);
        logic [3:0] one;
        one = 4'b0001 << d;
        return ~one;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_update(input logic [15:0] v);
        digits = v;
        update = 1'b1;
        step();
        update = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            step();
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_sel(input logic [1:0] s, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (digit_sel === s) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset;
        bit ok;
        reset = 1'b0; en = 1'b0; update = 1'b0; digits = '0;
        dp_in = '0; blink_mask = '0; dp_blink_mask = '0;
        step(); step();
        n_cmp++; if (anode !== 4'b1111) begin n_bad++; $display("FAIL reset_anode: got %b expected 1111", anode); end
        n_cmp++; if (segments !== 7'b1111111) begin n_bad++; $display("FAIL reset_seg: got %b expected 1111111", segments); end
        n_cmp++; if (dec_point !== 1'b1) begin n_bad++; $display("FAIL reset_dp: got %b expected 1", dec_point); end
        n_cmp++; if (digit_sel !== 2'd0) begin n_bad++; $display("FAIL reset_sel: got %0d expected 0", digit_sel); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        reset = 1'b1;
        en    = 1'b1;
        pulse_update(16'h1234);
        wait_frame(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL first_frame: got timeout expected frame_done"); end
        n_cmp++; if (cyc !== 16) begin n_bad++; $display("FAIL first_frame_time: got %0d expected 16", cyc); end
    endtask

    task automatic test_scan;
        for (int i = 0; i < 16; i++) begin
            step();
            n_cmp++; if (anode !== exp_anode(i/4)) begin n_bad++; $display("FAIL scan_anode[%0d]: got %b expected %b", i, anode, exp_anode(i/4)); end
            n_cmp++; if (segments !== exp_digit_seg(16'h1234, i/4)) begin n_bad++; $display("FAIL scan_seg[%0d]: got %b expected %b", i, segments, exp_digit_seg(16'h1234, i/4)); end
            n_cmp++; if (dec_point !== 1'b1) begin n_bad++; $display("FAIL scan_dp[%0d]: got %b expected 1", i, dec_point); end
            n_cmp++; if (frame_done !== (i == 15)) begin n_bad++; $display("FAIL scan_frame_done[%0d]: got %b expected %b", i, frame_done, (i == 15)); end
        end
    endtask

    task automatic test_frame_sync;
        bit ok;
        int osel;
        wait_sel(2'd1, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL sync_wait_sel: got timeout expected digit_sel 1"); end
        pulse_update(16'h5678);
        for (int t = 0; t < 40 && frame_done !== 1'b1; t++) begin
            osel = ((cyc - 1) / 4) % 4;
            n_cmp++; if (segments !== exp_digit_seg(16'h1234, osel)) begin n_bad++; $display("FAIL old_frame_hold[%0d]: got %b expected %b", osel, segments, exp_digit_seg(16'h1234, osel)); end
            step();
        end
        n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL sync_frame: got timeout expected frame_done"); end
        for (int i = 0; i < 16; i++) begin
            step();
            n_cmp++; if (anode !== exp_anode(i/4)) begin n_bad++; $display("FAIL new_frame_anode[%0d]: got %b expected %b", i, anode, exp_anode(i/4)); end
            n_cmp++; if (segments !== exp_digit_seg(16'h5678, i/4)) begin n_bad++; $display("FAIL new_frame_seg[%0d]: got %b expected %b", i, segments, exp_digit_seg(16'h5678, i/4)); end
        end
        // update presented exactly on the wrap cycle
        for (int t = 0; t < 20 && (cyc % 16) != 15; t++) step();
        pulse_update(16'hABCD);
        n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL wrap_update_pulse: got %b expected 1", frame_done); end
        for (int i = 0; i < 16; i++) begin
            step();
            n_cmp++; if (segments !== exp_digit_seg(16'hABCD, i/4)) begin n_bad++; $display("FAIL wrap_update_seg[%0d]: got %b expected %b", i, segments, exp_digit_seg(16'hABCD, i/4)); end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        wait_sel(2'd1, ok);
        pulse_update(16'h1111);
        wait_sel(2'd2, ok);
        pulse_update(16'hE0F9);
        wait_frame(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_frame: got timeout expected frame_done"); end
        for (int i = 0; i < 16; i++) begin
            step();
            n_cmp++; if (segments !== exp_digit_seg(16'hE0F9, i/4)) begin n_bad++; $display("FAIL b2b_last_wins[%0d]: got %b expected %b", i, segments, exp_digit_seg(16'hE0F9, i/4)); end
        end
    endtask

    task automatic test_blink;
        bit ok;
        int osel;
        int phase;
        logic blank;
        logic dp_on;
        logic [6:0] eseg;
        for (int pass = 0; pass < 2; pass++) begin
            dp_in         = 4'b0100;
            blink_mask    = (pass == 0) ? 4'b0100 : 4'b0000;
            dp_blink_mask = (pass == 0) ? 4'b0000 : 4'b0100;
            pulse_update(16'h1234);
            wait_frame(ok);
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL blink_frame[%0d]: got timeout expected frame_done", pass); end
            for (int i = 0; i < 96; i++) begin
                step();
                osel  = ((cyc - 1) / 4) % 4;
                phase = ((cyc - 1) / 32) % 2;
                blank = (phase == 1) && blink_mask[osel];
                dp_on = dp_in[osel] && !blank && !((phase == 1) && dp_blink_mask[osel]);
                eseg  = blank ? 7'b1111111 : exp_digit_seg(16'h1234, osel);
                n_cmp++; if (anode !== exp_anode(osel)) begin n_bad++; $display("FAIL blink_anode[%0d]: got %b expected %b", cyc, anode, exp_anode(osel)); end
                n_cmp++; if (segments !== eseg) begin n_bad++; $display("FAIL blink_seg[%0d]: got %b expected %b", cyc, segments, eseg); end
                n_cmp++; if (dec_point !== !dp_on) begin n_bad++; $display("FAIL blink_dp[%0d]: got %b expected %b", cyc, dec_point, !dp_on); end
            end
        end
    endtask

    task automatic test_enable;
        bit ok;
        int osel;
        dp_in = '0; blink_mask = '0; dp_blink_mask = '0;
        pulse_update(16'h1234);
        wait_frame(ok);
        wait_sel(2'd2, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL en_wait_sel: got timeout expected digit_sel 2"); end
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++; if (anode !== 4'b1111) begin n_bad++; $display("FAIL en_off_anode[%0d]: got %b expected 1111", i, anode); end
            n_cmp++; if (segments !== 7'b1111111) begin n_bad++; $display("FAIL en_off_seg[%0d]: got %b expected 1111111", i, segments); end
            n_cmp++; if (dec_point !== 1'b1) begin n_bad++; $display("FAIL en_off_dp[%0d]: got %b expected 1", i, dec_point); end
        end
        en = 1'b1;
        step();
        osel = ((cyc - 1) / 4) % 4;
        n_cmp++; if (anode !== exp_anode(osel)) begin n_bad++; $display("FAIL en_resume_anode: got %b expected %b", anode, exp_anode(osel)); end
        n_cmp++; if (segments !== exp_digit_seg(16'h1234, osel)) begin n_bad++; $display("FAIL en_resume_seg: got %b expected %b", segments, exp_digit_seg(16'h1234, osel)); end
        n_cmp++; if (digit_sel !== 2'((cyc / 4) % 4)) begin n_bad++; $display("FAIL en_resume_sel: got %0d expected %0d", digit_sel, (cyc / 4) % 4); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        wait_sel(2'd1, ok);
        pulse_update(16'h9999);
        wait_sel(2'd2, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rst_mid_wait_sel: got timeout expected digit_sel 2"); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (anode !== 4'b1111) begin n_bad++; $display("FAIL rst_mid_anode: got %b expected 1111", anode); end
        n_cmp++; if (segments !== 7'b1111111) begin n_bad++; $display("FAIL rst_mid_seg: got %b expected 1111111", segments); end
        n_cmp++; if (dec_point !== 1'b1) begin n_bad++; $display("FAIL rst_mid_dp: got %b expected 1", dec_point); end
        n_cmp++; if (digit_sel !== 2'd0) begin n_bad++; $display("FAIL rst_mid_sel: got %0d expected 0", digit_sel); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_frame_done: got %b expected 0", frame_done); end
        step();
        reset = 1'b1;
        wait_frame(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rst_mid_frame: got timeout expected frame_done"); end
        n_cmp++; if (cyc !== 16) begin n_bad++; $display("FAIL rst_mid_frame_time: got %0d expected 16", cyc); end
        for (int i = 0; i < 16; i++) begin
            step();
            n_cmp++; if (anode !== exp_anode(i/4)) begin n_bad++; $display("FAIL rst_mid_scan_anode[%0d]: got %b expected %b", i, anode, exp_anode(i/4)); end
            n_cmp++; if (segments !== exp_digit_seg(16'h0000, i/4)) begin n_bad++; $display("FAIL rst_mid_discard[%0d]: got %b expected %b", i, segments, exp_digit_seg(16'h0000, i/4)); end
        end
    endtask

    task automatic test_leading_zero;
        bit ok;
        pulse_update(16'h0042);
        wait_frame(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL lz_frame: got timeout expected frame_done"); end
        for (int i = 0; i < 16; i++) begin
            step();
            n_cmp++; if (segments !== exp_digit_seg(16'h0042, i/4)) begin n_bad++; $display("FAIL lz_seg[%0d]: got %b expected %b", i, segments, exp_digit_seg(16'h0042, i/4)); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_frame_sync();
        test_back_to_back();
        test_blink();
        test_enable();
        test_reset_mid();
        test_leading_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
